// File: rtl/store_buffer.sv
// store_buffer: store queue between the execute-stage store unit and the
// data-memory write port.
//
// Each offered store is aligned to its 32-bit word: byte strobes are computed
// and the data is replicated across lanes. Stores that are misaligned, or that
// use the illegal size, are rejected with a registered one-cycle pulse.
// Accepted stores enter a Depth-entry FIFO and drain in order over valid/ready.
//
// Optional feature: define STORE_BUFFER_LOAD_CHECK_EN to add a combinational
// load/store word-address conflict check.
//
// Ports:
//   clk_i               clock, all state updates on the rising edge
//   reset_i             synchronous active-high reset
//   store_addr_i        byte address of the offered store
//   store_val_i         store data, right-justified
//   store_size_i        0=byte, 1=half, 2=word, 3=illegal
//   store_valid_i       store request
//   store_ready_o       buffer not full
//   store_misaligned_o  offered store was rejected (one cycle after the offer)
//   mem_wr_addr_o       word address of the head entry (0 when empty)
//   mem_wr_data_o       lane-shifted data of the head entry (0 when empty)
//   mem_wr_strb_o       byte enables of the head entry (0 when empty)
//   mem_wr_valid_o      head entry present
//   mem_wr_ready_i      memory accepts the head entry
//   sb_empty_o          no entries queued
//   sb_count_o          current occupancy
//   load_chk_addr_i     (optional) load address to compare against the queue
//   load_conflict_o     (optional) some queued entry targets the same word
module store_buffer #(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            reset_i,
`ifdef STORE_BUFFER_LOAD_CHECK_EN
  input  logic [31:0]     load_chk_addr_i,
  output logic            load_conflict_o,
`endif
  input  logic [31:0]     store_addr_i,
  input  logic [31:0]     store_val_i,
  input  logic [1:0]      store_size_i,
  input  logic            store_valid_i,
  output logic            store_ready_o,
  output logic            store_misaligned_o,
  output logic [31:0]     mem_wr_addr_o,
  output logic [31:0]     mem_wr_data_o,
  output logic [3:0]      mem_wr_strb_o,
  output logic            mem_wr_valid_o,
  input  logic            mem_wr_ready_i,
  output logic            sb_empty_o,
  output logic [CntW-1:0] sb_count_o
);

  // Entry storage; only the word address is kept.
  logic [29:0] addr_mem_q [Depth];
  logic [31:0] data_mem_q [Depth];
  logic [3:0]  strb_mem_q [Depth];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            mis_q, mis_d;

  logic        full, empty, accept, enq, deq;
  logic        aligned;
  logic [1:0]  off;
  logic [3:0]  al_strb;
  logic [31:0] al_data;

  // Alignment of the offered store.
  always_comb begin
    off     = store_addr_i[1:0];
    aligned = 1'b0;
    al_strb = 4'b0000;
    al_data = store_val_i;
    unique case (store_size_i)
      2'd0: begin
        aligned = 1'b1;
        al_strb = 4'b0001 << off;
        al_data = {4{store_val_i[7:0]}};
      end
      2'd1: begin
        aligned = ~off[0];
        al_strb = 4'b0011 << off;
        al_data = {2{store_val_i[15:0]}};
      end
      2'd2: begin
        aligned = (off == 2'b00);
        al_strb = 4'b1111;
        al_data = store_val_i;
      end
      default: begin
        aligned = 1'b0;
      end
    endcase
  end

  assign full   = (count_q == CntW'(Depth));
  assign empty  = (count_q == '0);
  // A full buffer never accepts, even if the head drains this cycle.
  assign accept = store_valid_i & ~full;
  assign enq    = accept & aligned;
  assign deq    = ~empty & mem_wr_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mis_d    = accept & ~aligned;
    if (enq) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (deq) rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({enq, deq})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mis_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mis_q    <= mis_d;
    end
  end

  // Storage needs no reset: every read is masked by the occupancy count.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      addr_mem_q[wr_ptr_q] <= store_addr_i[31:2];
      data_mem_q[wr_ptr_q] <= al_data;
      strb_mem_q[wr_ptr_q] <= al_strb;
    end
  end

  always_comb begin
    mem_wr_addr_o = '0;
    mem_wr_data_o = '0;
    mem_wr_strb_o = '0;
    if (!empty) begin
      mem_wr_addr_o = {addr_mem_q[rd_ptr_q], 2'b00};
      mem_wr_data_o = data_mem_q[rd_ptr_q];
      mem_wr_strb_o = strb_mem_q[rd_ptr_q];
    end
  end

  assign store_ready_o      = ~full;
  assign store_misaligned_o = mis_q;
  assign mem_wr_valid_o     = ~empty;
  assign sb_empty_o         = empty;
  assign sb_count_o         = count_q;

`ifdef STORE_BUFFER_LOAD_CHECK_EN
  logic [PtrW-1:0] rel_slot;

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    load_conflict_o = 1'b0;
    rel_slot        = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      rel_slot = PtrW'(i) - rd_ptr_q;
      if ((CntW'(rel_slot) < count_q) && (addr_mem_q[i] == load_chk_addr_i[31:2])) begin
        load_conflict_o = 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed cases with literal
// expectations, then randomized traffic compared every cycle against a
// queue-based model of the buffer.
module tb_store_buffer;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } ent_t;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] store_addr_i;
  logic [31:0] store_val_i;
  logic [1:0]  store_size_i;
  logic        store_valid_i;
  logic        store_ready_o;
  logic        store_misaligned_o;
  logic [31:0] mem_wr_addr_o;
  logic [31:0] mem_wr_data_o;
  logic [3:0]  mem_wr_strb_o;
  logic        mem_wr_valid_o;
  logic        mem_wr_ready_i;
  logic        sb_empty_o;
  logic [2:0]  sb_count_o;
`ifdef STORE_BUFFER_LOAD_CHECK_EN
  logic [31:0] load_chk_addr_i;
  logic        load_conflict_o;
`endif

  store_buffer dut (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
`ifdef STORE_BUFFER_LOAD_CHECK_EN
    .load_chk_addr_i    (load_chk_addr_i),
    .load_conflict_o    (load_conflict_o),
`endif
    .store_addr_i       (store_addr_i),
    .store_val_i        (store_val_i),
    .store_size_i       (store_size_i),
    .store_valid_i      (store_valid_i),
    .store_ready_o      (store_ready_o),
    .store_misaligned_o (store_misaligned_o),
    .mem_wr_addr_o      (mem_wr_addr_o),
    .mem_wr_data_o      (mem_wr_data_o),
    .mem_wr_strb_o      (mem_wr_strb_o),
    .mem_wr_valid_o     (mem_wr_valid_o),
    .mem_wr_ready_i     (mem_wr_ready_i),
    .sb_empty_o         (sb_empty_o),
    .sb_count_o         (sb_count_o)
  );

  always #5 clk_i = ~clk_i;

  int   n_chk  = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;
  ent_t q[$];
  bit   exp_mis = 1'b0;
  ent_t head_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference alignment: strobe covers nb bytes starting at the offset,
  // every lane carries the store byte that lands there after replication.
  task automatic align(input logic [31:0] a, input logic [31:0] v, input logic [1:0] s,
                       output bit ok, output ent_t e);
    int nb;
    int off;
    nb     = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    off    = int'(a % 4);
    ok     = (s != 2'd3) && (off % nb == 0);
    e.addr = a - 32'(off);
    e.strb = 4'(((1 << nb) - 1) << off);
    for (int b = 0; b < 4; b++) e.data[b*8 +: 8] = v[(b % nb)*8 +: 8];
  endtask

  // Model: state as seen after each rising edge.
  always @(posedge clk_i) begin : model
    bit   ok;
    bit   do_deq;
    bit   acc;
    ent_t e;
    if (reset_i) begin
      q.delete();
      exp_mis <= 1'b0;
    end else begin
      do_deq = (q.size() > 0) && mem_wr_ready_i;
      acc    = store_valid_i && (q.size() < DEPTH);
      align(store_addr_i, store_val_i, store_size_i, ok, e);
      if (do_deq) void'(q.pop_front());
      if (acc && ok) q.push_back(e);
      exp_mis <= acc && !ok;
    end
  end

  // Compare on the falling edge, away from the sampling edge.
  always @(negedge clk_i) begin
    if (chk_en) begin
      head_m = '{addr: 32'h0, data: 32'h0, strb: 4'h0};
      if (q.size() > 0) head_m = q[0];
      check("store_ready", 32'(store_ready_o), 32'(q.size() < DEPTH));
      check("store_misaligned", 32'(store_misaligned_o), 32'(exp_mis));
      check("mem_wr_valid", 32'(mem_wr_valid_o), 32'(q.size() > 0));
      check("mem_wr_addr", mem_wr_addr_o, head_m.addr);
      check("mem_wr_data", mem_wr_data_o, head_m.data);
      check("mem_wr_strb", 32'(mem_wr_strb_o), 32'(head_m.strb));
      check("sb_empty", 32'(sb_empty_o), 32'(q.size() == 0));
      check("sb_count", 32'(sb_count_o), 32'(q.size()));
`ifdef STORE_BUFFER_LOAD_CHECK_EN
      begin
        bit hit;
        hit = 1'b0;
        foreach (q[i]) if (q[i].addr[31:2] == load_chk_addr_i[31:2]) hit = 1'b1;
        check("load_conflict", 32'(load_conflict_o), 32'(hit));
      end
`endif
    end
  end

  // Drive one cycle of inputs just after the rising edge.
  task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] s, input logic mr);
    @(posedge clk_i);
    #1;
    store_valid_i  = v;
    store_addr_i   = a;
    store_val_i    = d;
    store_size_i   = s;
    mem_wr_ready_i = mr;
  endtask

  initial begin
    reset_i        = 1'b1;
    store_valid_i  = 1'b0;
    store_addr_i   = '0;
    store_val_i    = '0;
    store_size_i   = '0;
    mem_wr_ready_i = 1'b0;
`ifdef STORE_BUFFER_LOAD_CHECK_EN
    load_chk_addr_i = '0;
`endif
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    chk_en  = 1'b1;

    // Reset state.
    @(negedge clk_i);
    check("rst store_ready", 32'(store_ready_o), 32'd1);
    check("rst mem_wr_valid", 32'(mem_wr_valid_o), 32'd0);
    check("rst sb_empty", 32'(sb_empty_o), 32'd1);
    check("rst sb_count", 32'(sb_count_o), 32'd0);
    check("rst mem_wr_addr", mem_wr_addr_o, 32'd0);

    // Byte store to the top lane.
    cyc(1, 32'h1003, 32'h0000_00AB, 2'd0, 1);
    cyc(0, 32'h0, 32'h0, 2'd0, 1);
    @(negedge clk_i);
    check("byte addr", mem_wr_addr_o, 32'h1000);
    check("byte strb", 32'(mem_wr_strb_o), 32'h8);
    check("byte lane3", 32'(mem_wr_data_o[31:24]), 32'hAB);
    cyc(0, 32'h0, 32'h0, 2'd0, 1);
    @(negedge clk_i);
    check("byte drained", 32'(sb_empty_o), 32'd1);

    // Rejected stores: misaligned half, misaligned word, illegal size.
    cyc(1, 32'h2001, 32'h1234, 2'd1, 1);
    cyc(0, 32'h0, 32'h0, 2'd0, 1);
    @(negedge clk_i);
    check("half mis pulse", 32'(store_misaligned_o), 32'd1);
    check("half mis count", 32'(sb_count_o), 32'd0);
    cyc(1, 32'h2002, 32'h1234, 2'd2, 1);
    cyc(0, 32'h0, 32'h0, 2'd0, 1);
    @(negedge clk_i);
    check("word mis pulse", 32'(store_misaligned_o), 32'd1);
    cyc(1, 32'h2000, 32'h1234, 2'd3, 1);
    cyc(0, 32'h0, 32'h0, 2'd0, 1);
    @(negedge clk_i);
    check("size3 mis pulse", 32'(store_misaligned_o), 32'd1);
    check("size3 count", 32'(sb_count_o), 32'd0);
    cyc(0, 32'h0, 32'h0, 2'd0, 1);
    @(negedge clk_i);
    check("mis pulse ends", 32'(store_misaligned_o), 32'd0);

    // Fill with the port stalled; a fifth store is held off.
    for (int i = 0; i < 4; i++) cyc(1, 32'h100 + 32'(4 * i), 32'hD0 + 32'(i), 2'd2, 0);
    for (int i = 0; i < 3; i++) cyc(1, 32'h5000, 32'hEEEE, 2'd2, 0);
    @(negedge clk_i);
    check("full ready", 32'(store_ready_o), 32'd0);
    check("full count", 32'(sb_count_o), 32'd4);
    check("stall data", mem_wr_data_o, 32'hD0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 32'h0, 32'h0, 2'd0, 1);
      @(negedge clk_i);
      check("drain order", mem_wr_addr_o, 32'h100 + 32'(4 * i));
      check("drain data", mem_wr_data_o, 32'hD0 + 32'(i));
    end
    cyc(0, 32'h0, 32'h0, 2'd0, 1);
    cyc(0, 32'h0, 32'h0, 2'd0, 1);

    // Simultaneous enqueue/dequeue across the pointer wrap.
    cyc(1, 32'h400, 32'hA0, 2'd2, 0);
    cyc(1, 32'h404, 32'hA1, 2'd2, 0);
    cyc(1, 32'h408, 32'hA2, 2'd2, 1);
    cyc(1, 32'h40C, 32'hA3, 2'd2, 1);
    cyc(0, 32'h0, 32'h0, 2'd0, 0);
    @(negedge clk_i);
    check("wrap count", 32'(sb_count_o), 32'd2);
    check("wrap head", mem_wr_addr_o, 32'h408);
    cyc(0, 32'h0, 32'h0, 2'd0, 1);
    @(negedge clk_i);
    cyc(0, 32'h0, 32'h0, 2'd0, 1);
    @(negedge clk_i);
    check("wrap second", mem_wr_addr_o, 32'h40C);
    cyc(0, 32'h0, 32'h0, 2'd0, 1);
    cyc(0, 32'h0, 32'h0, 2'd0, 1);

`ifdef STORE_BUFFER_LOAD_CHECK_EN
    cyc(1, 32'h3004, 32'h55, 2'd2, 0);
    cyc(0, 32'h0, 32'h0, 2'd0, 0);
    load_chk_addr_i = 32'h3006;
    @(negedge clk_i);
    check("ld same word", 32'(load_conflict_o), 32'd1);
    load_chk_addr_i = 32'h3008;
    #1;
    check("ld next word", 32'(load_conflict_o), 32'd0);
    cyc(0, 32'h0, 32'h0, 2'd0, 1);
    cyc(0, 32'h0, 32'h0, 2'd0, 1);
    load_chk_addr_i = 32'h3006;
    @(negedge clk_i);
    check("ld after drain", 32'(load_conflict_o), 32'd0);
`endif

    // Randomized traffic, with occasional mid-operation resets.
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
          32'h4000 | 32'($urandom_range(0, 31)),
          $urandom(),
          2'($urandom_range(0, 3)),
          $urandom_range(0, 1) == 1);
      reset_i = ($urandom_range(0, 199) == 0);
`ifdef STORE_BUFFER_LOAD_CHECK_EN
      load_chk_addr_i = 32'h4000 | 32'($urandom_range(0, 31));
`endif
    end
    cyc(0, 32'h0, 32'h0, 2'd0, 1);
    reset_i = 1'b0;
    repeat (6) cyc(0, 32'h0, 32'h0, 2'd0, 1);
    @(negedge clk_i);
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
